// File: rtl/decimal_to_binary_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The master drives the request and the BCD digits; the slave returns status and results.
interface decimal_to_binary_if;
    logic        start;
    logic        negative;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  binary;
    logic [15:0] Accel_Data;

    modport master (
        output start, negative, thousands, hundreds, tens, ones,
        input  busy, done, error, binary, Accel_Data
    );

    modport slave (
        input  start, negative, thousands, hundreds, tens, ones,
        output busy, done, error, binary, Accel_Data
    );
endinterface

// File: rtl/decimal_to_binary.sv
// Sign plus four BCD digits to a 10-bit two's-complement accelerometer sample, using an
// iterative reverse double-dabble with a fixed 16-cycle start-to-done latency.
module decimal_to_binary (
    input  logic                  clk,
    input  logic                  reset_n,
    decimal_to_binary_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic [3:0] LAST_ITER = 4'd13;

    logic [1:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic        neg_q,    neg_d;
    logic        bad_q,    bad_d;
    logic [29:0] shreg_q,  shreg_d;
    logic        done_q,   done_d;
    logic        error_q,  error_d;
    logic [9:0]  binary_q, binary_d;
    logic [15:0] accel_q,  accel_d;

    // One reverse double-dabble step: shift right, then pull each BCD field >= 8 down by 3.
    logic [29:0] shifted;
    logic [29:0] stepped;
    assign shifted       = shreg_q >> 1;
    assign stepped[13:0] = shifted[13:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bcd_fix
            logic [3:0] field;
            assign field = shifted[14 + 4*gi +: 4];
            assign stepped[14 + 4*gi +: 4] = (field >= 4'd8) ? (field - 4'd3) : field;
        end
    endgenerate

    logic [3:0] digit_bad;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (shreg_q[14 + 4*gi +: 4] > 4'd9);
        end
    endgenerate

    logic [13:0] mag;
    logic        out_of_range;
    logic [9:0]  bin_val;
    assign mag          = shreg_q[13:0];
    assign out_of_range = neg_q ? (mag > 14'd512) : (mag > 14'd511);
    assign bin_val      = neg_q ? (~mag[9:0] + 10'd1) : mag[9:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        bad_d    = bad_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
        error_d  = error_q;
        binary_d = binary_q;
        accel_d  = accel_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    neg_d   = bus.negative;
                    shreg_d = {bus.thousands, bus.hundreds, bus.tens, bus.ones, 14'd0};
                    cnt_d   = 4'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                bad_d   = |digit_bad;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Runs the full 14 steps even for bad digits so latency never varies.
                shreg_d = stepped;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (bad_q || out_of_range) begin
                    error_d  = 1'b1;
                    binary_d = 10'd0;
                    accel_d  = 16'd0;
                end else begin
                    error_d  = 1'b0;
                    binary_d = bin_val;
                    accel_d  = {bin_val[2:0], 6'd0, bin_val[9:3]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            neg_q    <= 1'b0;
            bad_q    <= 1'b0;
            shreg_q  <= 30'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            binary_q <= 10'd0;
            accel_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            bad_q    <= bad_d;
            shreg_q  <= shreg_d;
            done_q   <= done_d;
            error_q  <= error_d;
            binary_q <= binary_d;
            accel_q  <= accel_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.binary     = binary_q;
    assign bus.Accel_Data = accel_q;
endmodule

// File: tb/tb_decimal_to_binary.sv
// Scoreboard bench for decimal_to_binary: expectations are queued when a conversion is
// launched and popped when done is observed.
module tb_decimal_to_binary;
    typedef struct packed {
        logic        err;
        logic [9:0]  bin;
        logic [15:0] acc;
    } exp_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] th;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   accept_cyc;
    exp_t sb[$];
    exp_t last_exp = '0;

    decimal_to_binary_if bus_if ();

    decimal_to_binary dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t model(input logic neg, input logic [3:0] th, input logic [3:0] h,
                                   input logic [3:0] t, input logic [3:0] o);
        exp_t       e;
        int         mag;
        logic [9:0] b;
        e   = '0;
        mag = int'(th) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(o);
        if (th > 9 || h > 9 || t > 9 || o > 9 || (!neg && mag > 511) || (neg && mag > 512)) begin
            e.err = 1'b1;
        end else begin
            b     = neg ? 10'((1024 - mag) % 1024) : 10'(mag);
            e.bin = b;
            e.acc = {b[2:0], 6'd0, b[9:3]};
        end
        return e;
    endfunction

    task automatic set_inputs(input vec_t v);
        bus_if.negative  = v.neg;
        bus_if.thousands = v.th;
        bus_if.hundreds  = v.h;
        bus_if.tens      = v.t;
        bus_if.ones      = v.o;
    endtask

    // Drives one start pulse; on return we are #1 after the accepting edge.
    task automatic launch(input vec_t v);
        @(negedge clk);
        set_inputs(v);
        bus_if.start = 1'b1;
        sb.push_back(model(v.neg, v.th, v.h, v.t, v.o));
        @(posedge clk);
        #1;
        accept_cyc = cyc_cnt;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int done_cyc, output bit seen);
        int n;
        n    = 0;
        seen = 1'b0;
        done_cyc = -1;
        while (!seen && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_if.done) begin
                seen = 1'b1;
                done_cyc = cyc_cnt;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_if.start = 1'b0;
        set_inputs('0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.error, bus_if.binary, bus_if.Accel_Data} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b bin=%h acc=%h, need all 0",
                     bus_if.busy, bus_if.done, bus_if.error, bus_if.binary, bus_if.Accel_Data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset: outputs busy=%b done=%b bin=%h", bus_if.busy, bus_if.done, bus_if.binary);
    endtask

    task automatic test_values();
        vec_t tbl[12];
        int   dcyc;
        bit   seen;
        exp_t e;
        tbl = '{ '{1'b0,4'd0,4'd1,4'd2,4'd3}, '{1'b1,4'd0,4'd5,4'd1,4'd2},
                 '{1'b1,4'd0,4'd0,4'd0,4'd1}, '{1'b1,4'd0,4'd0,4'd0,4'd0},
                 '{1'b0,4'd0,4'd5,4'd1,4'd1}, '{1'b0,4'd0,4'd5,4'd1,4'd2},
                 '{1'b1,4'd0,4'd5,4'd1,4'd3}, '{1'b0,4'd9,4'd9,4'd9,4'd9},
                 '{1'b0,4'd0,4'd0,4'hA,4'd0}, '{1'b1,4'd0,4'd2,4'd5,4'd6},
                 '{1'b0,4'hF,4'd0,4'd0,4'd1}, '{1'b0,4'd0,4'd3,4'd8,4'd7} };
        foreach (tbl[i]) begin
            launch(tbl[i]);
            checks++;
            if (bus_if.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_rise[%0d]: got %b, need 1", i, bus_if.busy);
            end
            wait_done(40, dcyc, seen);
            checks++;
            if (!seen || dcyc - accept_cyc !== 16) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d cycles (seen=%b), need 16", i, dcyc - accept_cyc, seen);
            end
            if (seen) begin
                e = sb.pop_front();
                last_exp = e;
                checks++;
                if ({bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
                    errors++;
                    $display("FAIL value[%0d]: got err=%b bin=%h acc=%h, need err=%b bin=%h acc=%h",
                             i, bus_if.error, bus_if.binary, bus_if.Accel_Data, e.err, e.bin, e.acc);
                end
                checks++;
                if (bus_if.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done[%0d]: got %b, need 0", i, bus_if.busy);
                end
                $display("value %s%h%h%h%h: err=%b bin=%h acc=%h", tbl[i].neg ? "-" : "+",
                         tbl[i].th, tbl[i].h, tbl[i].t, tbl[i].o, bus_if.error, bus_if.binary, bus_if.Accel_Data);
            end else begin
                void'(sb.pop_front());
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.done !== 1'b0 || {bus_if.error, bus_if.binary, bus_if.Accel_Data} !== last_exp) begin
                errors++;
                $display("FAIL done_pulse_hold[%0d]: got done=%b bin=%h, need done=0 bin=%h",
                         i, bus_if.done, bus_if.binary, last_exp.bin);
            end
        end
    endtask

    task automatic test_ignored_start();
        int   dcyc;
        int   extra;
        bit   seen;
        exp_t e;
        launch('{1'b0, 4'd0, 4'd0, 4'd4, 4'd2});
        repeat (3) @(negedge clk);
        set_inputs('{1'b1, 4'd0, 4'd1, 4'd0, 4'd0});
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(40, dcyc, seen);
        checks++;
        if (!seen || dcyc - accept_cyc !== 16) begin
            errors++;
            $display("FAIL ignored_latency: got %0d cycles (seen=%b), need 16", dcyc - accept_cyc, seen);
        end
        e = sb.pop_front();
        last_exp = e;
        checks++;
        if ({bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
            errors++;
            $display("FAIL ignored_value: got bin=%h acc=%h, need bin=%h acc=%h",
                     bus_if.binary, bus_if.Accel_Data, e.bin, e.acc);
        end
        extra = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (bus_if.done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignored_no_second_done: got %0d extra dones, need 0", extra);
        end
        $display("ignored_start: bin=%h extra_dones=%0d", last_exp.bin, extra);
    endtask

    task automatic test_input_change();
        int   dcyc;
        bit   seen;
        exp_t e;
        launch('{1'b1, 4'd0, 4'd3, 4'd0, 4'd0});
        @(negedge clk);
        set_inputs('{1'b0, 4'd9, 4'd9, 4'd9, 4'd9});
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.error, bus_if.binary, bus_if.Accel_Data} !== last_exp) begin
            errors++;
            $display("FAIL hold_while_busy: got bin=%h, need bin=%h", bus_if.binary, last_exp.bin);
        end
        wait_done(40, dcyc, seen);
        e = sb.pop_front();
        last_exp = e;
        checks++;
        if (!seen || {bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
            errors++;
            $display("FAIL input_change_value: got err=%b bin=%h (seen=%b), need err=%b bin=%h",
                     bus_if.error, bus_if.binary, seen, e.err, e.bin);
        end
        $display("input_change: bin=%h err=%b", bus_if.binary, bus_if.error);
    endtask

    task automatic test_back_to_back();
        int   dcyc;
        bit   seen;
        exp_t e;
        vec_t vb;
        launch('{1'b0, 4'd0, 4'd0, 4'd7, 4'd7});
        bus_if.start = 1'b1;
        wait_done(40, dcyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
            errors++;
            $display("FAIL b2b_first: got bin=%h (seen=%b), need bin=%h", bus_if.binary, seen, e.bin);
        end
        vb = '{1'b1, 4'd0, 4'd1, 4'd9, 4'd9};
        set_inputs(vb);
        sb.push_back(model(vb.neg, vb.th, vb.h, vb.t, vb.o));
        @(posedge clk);
        #1;
        accept_cyc = cyc_cnt;
        bus_if.start = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b, need busy=1 done=0", bus_if.busy, bus_if.done);
        end
        wait_done(40, dcyc, seen);
        e = sb.pop_front();
        last_exp = e;
        checks++;
        if (!seen || dcyc - accept_cyc !== 16 || {bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
            errors++;
            $display("FAIL b2b_second: got %0d cycles bin=%h acc=%h, need 16 cycles bin=%h acc=%h",
                     dcyc - accept_cyc, bus_if.binary, bus_if.Accel_Data, e.bin, e.acc);
        end
        $display("back_to_back: second bin=%h acc=%h", bus_if.binary, bus_if.Accel_Data);
    endtask

    task automatic test_reset_mid();
        int   dcyc;
        int   extra;
        bit   seen;
        exp_t e;
        launch('{1'b0, 4'd0, 4'd1, 4'd2, 4'd3});
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.error, bus_if.binary, bus_if.Accel_Data} !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b bin=%h acc=%h, need all 0",
                     bus_if.busy, bus_if.binary, bus_if.Accel_Data);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (bus_if.done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d dones, need 0", extra);
        end
        launch('{1'b1, 4'd0, 4'd0, 4'd0, 4'd5});
        wait_done(40, dcyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || dcyc - accept_cyc !== 16 || {bus_if.error, bus_if.binary, bus_if.Accel_Data} !== e) begin
            errors++;
            $display("FAIL reset_recover: got bin=%h acc=%h (seen=%b), need bin=%h acc=%h",
                     bus_if.binary, bus_if.Accel_Data, seen, e.bin, e.acc);
        end
        $display("reset_mid: extra_dones=%0d recover bin=%h", extra, bus_if.binary);
    endtask

    initial begin
        test_reset();
        test_values();
        test_ignored_start();
        test_input_change();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decimal_to_binary.md
# decimal_to_binary

Sequential BCD-to-binary converter, the inverse of the accelerometer binary-to-decimal path. It takes a sign and four BCD digits (for example, a user-entered acceleration threshold or a test value) and produces the matching 10-bit two's-complement sample. It also emits that sample packed in the 16-bit accelerometer register format, so it can be compared against or injected in place of live SPI data. Conversion is an iterative reverse double-dabble under a start/busy/done handshake.

## Interface
- No parameters; widths are fixed by the accelerometer data format.
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- negative  input  1  sign of the decimal value (1 = negative).
- thousands  input  4  BCD digit, most significant.
- hundreds  input  4  BCD digit.
- tens  input  4  BCD digit.
- ones  input  4  BCD digit, least significant.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when results are updated.
- error  output  1  last conversion was invalid; valid alongside done, held until next done.
- binary  output  10  two's-complement result; held until next done.
- Accel_Data  output  16  result in register packing; held until next done.

## Operation
- Inputs are latched on the edge that accepts start, so they may change while busy is high.
- States:
  - IDLE: if start=1, latch inputs, clear the shift counter, go to CHECK.
  - CHECK: record whether any latched digit is greater than 9 (bad_digit flag); go to SHIFT.
  - SHIFT: exactly 14 iterations, one per cycle, then go to FINISH.
  - FINISH: compute and register outputs, set done, go to IDLE.
- Each SHIFT iteration works on a 30-bit register {BCD[15:0], bin[13:0]}:
  - Shift the whole register right by 1.
  - Then, for each 4-bit BCD field that is at least 8, subtract 3 from it.
- After 14 iterations, bin[13:0] is the unsigned magnitude (0..9999).
- SHIFT runs even when bad_digit is set, so latency is constant.
- FINISH, error cases. error=1, binary=0 and Accel_Data=0 when any of these hold:
  - bad_digit is set;
  - negative=0 and magnitude > 511;
  - negative=1 and magnitude > 512.
- FINISH, valid case:
  - error=0.
  - binary = negative ? (~mag[9:0] + 1) : mag[9:0], computed modulo 2^10.
  - -0 yields 10'h000 with error=0.
- Accel_Data packing:
  - [15:13] = binary[2:0]
  - [12:7] = 0
  - [6:0] = binary[9:3]
- A start received while busy=1 is ignored and not queued.

## Timing
- Reset (asynchronous, reset_n=0): state=IDLE, busy=0, done=0, error=0, binary=0, Accel_Data=0, internal registers cleared.
- Reset mid-conversion aborts it: no done pulse, outputs return to 0.
- Let edge E be the edge that samples start=1 in IDLE:
  - busy rises after E and is high for 16 cycles (CHECK, SHIFT×14, FINISH).
  - On edge E+16 the outputs update, done=1 and busy=0.
  - On edge E+17 done clears.
  - Fixed latency is 16 cycles from acceptance to done, error or not.
- start=1 in the cycle where done=1 is accepted (state is IDLE), so back-to-back throughput is one result per 16 cycles.
- error, binary and Accel_Data change only on the done edge; they are stable at all other times.

## Test plan
- Basic positive: negative=0, digits 0,1,2,3, start pulse → after 16 cycles done=1 for one cycle, binary=10'h07B, Accel_Data=16'h600F, error=0.
- Negative range limits:
  - -0512 → binary=10'h200, Accel_Data=16'h0040, error=0.
  - -0001 → binary=10'h3FF, Accel_Data=16'hE07F.
  - -0000 → binary=10'h000, error=0.
- Out-of-range values:
  - +0511 → binary=10'h1FF, error=0.
  - +0512 → error=1, binary=0, Accel_Data=0.
  - -0513 and +9999 → error=1.
- Invalid BCD: tens=4'hA → error=1, binary=0, done still exactly 16 cycles after start.
- Handshake:
  - Start pulses during busy are ignored: exactly one done, with the original inputs' result.
  - Inputs changed mid-conversion do not affect the result.
  - start held high through done → second conversion accepted in the done cycle, second done 16 cycles later.
- Reset: assert reset_n=0 at cycle 8 of a conversion → all outputs 0 immediately, no done pulse afterwards. A new start after release converts correctly.
